axi4_protocol_monitor: RTL and testbench
========================================

// Module: axi4_protocol_monitor
// PURPOSE
//  Passive, parametrised AXI4-Full protocol monitor. It taps a master/slave pair alongside dut_if.
//  It tracks AW/W/B and AR/R bursts with per-direction length FIFOs and checks beat counts against
//  AxLEN, plus burst legality (4KB, WRAP length).
//  Reports sticky error bits, a per-cycle error pulse and saturating traffic counters to the sim
//  env or on-chip debug.
// PARAMETERS
//  ID_WIDTH         1   AxID/xID width (observed only, no ordering checks)
//  ADDR_WIDTH       32  AxADDR width (>=12)
//  MAX_OUTSTANDING  4   depth of each AxLEN tracking FIFO (power of 2, >=2)
//  CNT_WIDTH        32  width of every traffic counter
// PORTS
//  ACLK            in   1            clock, all logic rising-edge
//  ARESETN         in   1            async active-low reset
//  CLEAR           in   1            sync clear of counters + sticky errors
//  AWVALID/AWREADY in   1/1          write addr handshake
//  AWADDR          in   ADDR_WIDTH   write addr
//  AWLEN/AWSIZE/AWBURST  in  8/3/2   write burst attributes
//  WVALID/WREADY/WLAST   in  1/1/1   write data handshake + last
//  BVALID/BREADY   in   1/1          write resp handshake
//  BRESP           in   2            write resp code
//  ARVALID/ARREADY in   1/1          read addr handshake
//  ARADDR          in   ADDR_WIDTH   read addr
//  ARLEN/ARSIZE/ARBURST  in  8/3/2   read burst attributes
//  RVALID/RREADY/RLAST   in  1/1/1   read data handshake + last
//  RRESP           in   2            read resp code
//  ERR             out  9            sticky error vector (bits below)
//  ERR_PULSE       out  1            1-cycle strobe, any new error this cycle
//  WR_BURSTS/RD_BURSTS   out  CNT_WIDTH   completed B / RLAST handshakes
//  WR_BEATS/RD_BEATS     out  CNT_WIDTH   W / R beat handshakes
//  RESP_ERR_CNT    out  CNT_WIDTH    B or R handshakes with resp!=OKAY (each counts 1)
//  WR_OUTSTANDING/RD_OUTSTANDING  out  $clog2(MAX_OUTSTANDING)+1  AW-minus-B / AR-minus-RLAST
// BEHAVIOUR
//  Handshake = VALID&READY at ACLK edge. Outputs registered; ERR bit and ERR_PULSE appear 1 cycle after handshake.
//  Reset: every output 0, FIFOs empty, both FSMs IDLE, beat counters 0. Mid-burst reset discards tracking, no error.
//  ERR bits:
//   0 WLAST_EARLY       1 WLAST_MISSING    2 W_NO_AW
//   3 B_UNEXPECTED      4 RLAST_MISMATCH   5 R_NO_AR
//   6 FIFO_OVERFLOW     7 BURST_ILLEGAL    8 RESERVED (0)
//  Addr handshake pushes AxLEN into FIFO. Push when full: ERR[6], entry dropped, outstanding unchanged.
//  BURST_ILLEGAL (on AW or AR handshake) when any of:
//   - AxBURST==2'b11;
//   - WRAP with AxLEN not in {1,3,7,15};
//   - INCR with AxADDR[11:0] + ((AxLEN+1)<<AxSIZE) > 4096. Compute this sum in 17 bits.
//  W FSM: W_IDLE -> W_ACTIVE on first beat, load len from FIFO head; beat_cnt counts 0..len.
//   - WLAST && beat_cnt<len: ERR[0], pop, -> W_IDLE.
//   - beat_cnt==len && !WLAST: ERR[1], pop, -> W_IDLE.
//   - WLAST at beat_cnt==len: pop, wdone++ , -> W_IDLE. Single-beat burst (len 0) completes from W_IDLE.
//   - W beat with FIFO empty and no same-cycle AW: ERR[2], beat counted, ignored by FSM.
//   - Same-cycle AW push + W beat on empty FIFO: bypass, beat checked against incoming AWLEN, no error.
//  B: handshake with wdone==0 and no same-cycle WLAST completion -> ERR[3]. Otherwise wdone--, WR_BURSTS++, outstanding--.
//  R FSM identical to W: ERR[4] for early or missing RLAST, ERR[5] for beat with no AR. Bypass rule applies.
//   - Normal completion: RD_BURSTS++, outstanding--.
//  Simultaneous push+pop on one FIFO: occupancy unchanged. Full and pop same cycle: push accepted.
//  Counters saturate at all-ones, no wrap. CLEAR zeroes counters and ERR only; FIFOs, FSMs, outstanding untouched.
//  CLEAR with new error same cycle: new error bit set, ERR_PULSE=1.
// STRUCTURE
//  Package axi4_mon_pkg:
//   - ERR_* bit index localparams;
//   - burst_e {FIXED=0,INCR=1,WRAP=2};
//   - resp_e {OKAY,EXOKAY,SLVERR,DECERR};
//   - function crosses_4k(addr12,len,size).
//  Sub-module axi4_mon_len_fifo: sync FIFO of 8-bit len, DEPTH=MAX_OUTSTANDING, full/empty/count outputs.
//   Instantiated twice (W, R). Channel FSMs + counters live in top.
// TESTING
//  1 ARESETN low mid-burst -> all outputs 0, next legal burst gives ERR=0.
//  2 AW addr 0x1000 len 3 size 2 INCR, 4 W beats WLAST on 4th, B OKAY -> ERR=0, WR_BEATS=4, WR_BURSTS=1, WR_OUTSTANDING 1->0.
//  3 AWLEN=3, WLAST on beat 2 -> ERR[0]=1 next cycle, ERR_PULSE one cycle, following legal burst clean.
//  4 AR addr 0xFF0 len 7 size 2 INCR (end 0x1010) -> ERR[7]. WRAP len 4 -> ERR[7]. WRAP len 3 addr 0x08 -> none.
//  5 MAX_OUTSTANDING=4, 5 AW without W -> ERR[6] on 5th, WR_OUTSTANDING=4. B with no W -> ERR[3].
//  6 Same cycle AW len 0 + W beat WLAST on empty FIFO -> no error. CLEAR coincident with RLAST-missing -> ERR=9'h010, counters 0.

Source files
------------

// File: rtl/axi4_mon_pkg.sv
// Shared types, error bit positions and burst legality helpers for the AXI4 protocol monitor.
package axi4_mon_pkg;

  localparam int ERR_WIDTH          = 9;
  localparam int ERR_WLAST_EARLY    = 0;
  localparam int ERR_WLAST_MISSING  = 1;
  localparam int ERR_W_NO_AW        = 2;
  localparam int ERR_B_UNEXPECTED   = 3;
  localparam int ERR_RLAST_MISMATCH = 4;
  localparam int ERR_R_NO_AR        = 5;
  localparam int ERR_FIFO_OVERFLOW  = 6;
  localparam int ERR_BURST_ILLEGAL  = 7;
  localparam int ERR_RESERVED       = 8;

  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_e;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_e;
  typedef enum logic {CH_IDLE, CH_ACTIVE} chan_state_e;

  // 17-bit sum so that a 256-beat, 128-byte burst from 0xFFF cannot wrap.
  function automatic logic crosses_4k(input logic [11:0] addr12, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [16:0] span;
    logic [16:0] endAddr;
    span    = ({9'd0, len} + 17'd1) << size;
    endAddr = {5'd0, addr12} + span;
    return endAddr > 17'd4096;
  endfunction

  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len,
                                         input logic [11:0] addr12, input logic [2:0] size);
    if (burst == 2'b11) return 1'b1;
    if (burst == WRAP)  return !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    if (burst == INCR)  return crosses_4k(addr12, len, size);
    return 1'b0;
  endfunction

endpackage

// File: rtl/axi4_mon_len_fifo.sv
// Synchronous FIFO holding the AxLEN of each accepted address phase until its data burst ends.
module axi4_mon_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             data_i,
  output logic [7:0]             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q;
  logic          pushEn, popEn;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign popEn  = pop_i && !empty_o;
  assign pushEn = push_i && (!full_o || popEn);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + PW'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_q + (PW+1)'(pushEn) - (PW+1)'(popEn);
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 monitor: tracks write/read bursts against AxLEN, flags protocol errors
// with sticky bits and a pulse, and keeps saturating traffic counters.
module axi4_protocol_monitor
  import axi4_mon_pkg::*;
#(
  parameter int ID_WIDTH        = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               CLEAR,
  input  logic                               AWVALID,
  input  logic                               AWREADY,
  input  logic [ADDR_WIDTH-1:0]              AWADDR,
  input  logic [7:0]                         AWLEN,
  input  logic [2:0]                         AWSIZE,
  input  logic [1:0]                         AWBURST,
  input  logic                               WVALID,
  input  logic                               WREADY,
  input  logic                               WLAST,
  input  logic                               BVALID,
  input  logic                               BREADY,
  input  logic [1:0]                         BRESP,
  input  logic                               ARVALID,
  input  logic                               ARREADY,
  input  logic [ADDR_WIDTH-1:0]              ARADDR,
  input  logic [7:0]                         ARLEN,
  input  logic [2:0]                         ARSIZE,
  input  logic [1:0]                         ARBURST,
  input  logic                               RVALID,
  input  logic                               RREADY,
  input  logic                               RLAST,
  input  logic [1:0]                         RRESP,
  output logic [ERR_WIDTH-1:0]               ERR,
  output logic                               ERR_PULSE,
  output logic [CNT_WIDTH-1:0]               WR_BURSTS,
  output logic [CNT_WIDTH-1:0]               RD_BURSTS,
  output logic [CNT_WIDTH-1:0]               WR_BEATS,
  output logic [CNT_WIDTH-1:0]               RD_BEATS,
  output logic [CNT_WIDTH-1:0]               RESP_ERR_CNT,
  output logic [$clog2(MAX_OUTSTANDING):0]   WR_OUTSTANDING,
  output logic [$clog2(MAX_OUTSTANDING):0]   RD_OUTSTANDING
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  function automatic logic [OW-1:0] udStep(input logic [OW-1:0] v, input logic inc, input logic dec);
    if (inc && !dec && v != '1) return v + OW'(1);
    if (dec && !inc && v != '0) return v - OW'(1);
    return v;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] v, input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, v} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic awHs, wHs, bHs, arHs, rHs;
  assign awHs = AWVALID && AWREADY;
  assign wHs  = WVALID && WREADY;
  assign bHs  = BVALID && BREADY;
  assign arHs = ARVALID && ARREADY;
  assign rHs  = RVALID && RREADY;

  logic [7:0]    wHead, rHead;
  logic          wFull, wEmpty, rFull, rEmpty;
  logic [OW-1:0] wCount, rCount;
  logic          wFifoPush, wFifoPop, rFifoPush, rFifoPop;

  chan_state_e wState_q, wState_d, rState_q, rState_d;
  logic [7:0]  wLen_q, wLen_d, wCnt_q, wCnt_d, wCurLen, wIdx;
  logic [7:0]  rLen_q, rLen_d, rCnt_q, rCnt_d, rCurLen, rIdx;
  logic        wPop, wDone, wEarly, wMissing, wNoAddr, wBypass;
  logic        rPop, rDone, rEarly, rMissing, rNoAddr, rBypass;

  logic [OW-1:0] wDoneCnt_q, wrOut_q, rdOut_q;
  logic [ERR_WIDTH-1:0] err_q, newErr;
  logic errPulse_q;
  logic [CNT_WIDTH-1:0] wrBursts_q, rdBursts_q, wrBeats_q, rdBeats_q, respErr_q;
  logic bUnexp, bOk, awAccept, arAccept, wOvf, rOvf;
  logic [1:0] respInc;

  // Write data tracker; the first beat takes its length from the FIFO head, or from
  // a same-cycle AW when the FIFO is empty.
  always_comb begin
    wState_d = wState_q;
    wLen_d   = wLen_q;
    wCnt_d   = wCnt_q;
    wCurLen  = wLen_q;
    wIdx     = wCnt_q;
    {wPop, wDone, wEarly, wMissing, wNoAddr, wBypass} = '0;
    if (wHs) begin
      if (wState_q == CH_IDLE) begin
        wIdx = 8'd0;
        if (!wEmpty)   wCurLen = wHead;
        else if (awHs) begin wCurLen = AWLEN; wBypass = 1'b1; end
        else           wNoAddr = 1'b1;
      end
      if (!wNoAddr) begin
        if (WLAST && wIdx == wCurLen) begin wDone = 1'b1;    wPop = 1'b1; wState_d = CH_IDLE; end
        else if (WLAST)               begin wEarly = 1'b1;   wPop = 1'b1; wState_d = CH_IDLE; end
        else if (wIdx == wCurLen)     begin wMissing = 1'b1; wPop = 1'b1; wState_d = CH_IDLE; end
        else begin
          wState_d = CH_ACTIVE;
          wLen_d   = wCurLen;
          wCnt_d   = wIdx + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rState_d = rState_q;
    rLen_d   = rLen_q;
    rCnt_d   = rCnt_q;
    rCurLen  = rLen_q;
    rIdx     = rCnt_q;
    {rPop, rDone, rEarly, rMissing, rNoAddr, rBypass} = '0;
    if (rHs) begin
      if (rState_q == CH_IDLE) begin
        rIdx = 8'd0;
        if (!rEmpty)   rCurLen = rHead;
        else if (arHs) begin rCurLen = ARLEN; rBypass = 1'b1; end
        else           rNoAddr = 1'b1;
      end
      if (!rNoAddr) begin
        if (RLAST && rIdx == rCurLen) begin rDone = 1'b1;    rPop = 1'b1; rState_d = CH_IDLE; end
        else if (RLAST)               begin rEarly = 1'b1;   rPop = 1'b1; rState_d = CH_IDLE; end
        else if (rIdx == rCurLen)     begin rMissing = 1'b1; rPop = 1'b1; rState_d = CH_IDLE; end
        else begin
          rState_d = CH_ACTIVE;
          rLen_d   = rCurLen;
          rCnt_d   = rIdx + 8'd1;
        end
      end
    end
  end

  // A bypassed burst that ends on its first beat never needs to enter the FIFO.
  assign wFifoPush = awHs && !(wBypass && wPop);
  assign wFifoPop  = wPop && !wBypass;
  assign rFifoPush = arHs && !(rBypass && rPop);
  assign rFifoPop  = rPop && !rBypass;
  assign wOvf      = awHs && wFull && !wFifoPop;
  assign rOvf      = arHs && rFull && !rFifoPop;
  assign awAccept  = awHs && !wOvf;
  assign arAccept  = arHs && !rOvf;
  assign bUnexp    = bHs && (wDoneCnt_q == '0) && !wDone;
  assign bOk       = bHs && !bUnexp;
  assign respInc   = {1'b0, bHs && (BRESP != OKAY)} + {1'b0, rHs && (RRESP != OKAY)};

  always_comb begin
    newErr                     = '0;
    newErr[ERR_WLAST_EARLY]    = wEarly;
    newErr[ERR_WLAST_MISSING]  = wMissing;
    newErr[ERR_W_NO_AW]        = wNoAddr;
    newErr[ERR_B_UNEXPECTED]   = bUnexp;
    newErr[ERR_RLAST_MISMATCH] = rEarly || rMissing;
    newErr[ERR_R_NO_AR]        = rNoAddr;
    newErr[ERR_FIFO_OVERFLOW]  = wOvf || rOvf;
    newErr[ERR_BURST_ILLEGAL]  = (awHs && burst_illegal(AWBURST, AWLEN, AWADDR[11:0], AWSIZE)) ||
                                 (arHs && burst_illegal(ARBURST, ARLEN, ARADDR[11:0], ARSIZE));
    newErr[ERR_RESERVED]       = 1'b0;
  end

  // CLEAR wipes counters outright but still lets this cycle's new errors land.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wState_q <= CH_IDLE;  rState_q <= CH_IDLE;
      wLen_q <= '0;  wCnt_q <= '0;  rLen_q <= '0;  rCnt_q <= '0;
      wDoneCnt_q <= '0;  wrOut_q <= '0;  rdOut_q <= '0;
      err_q <= '0;  errPulse_q <= 1'b0;
      wrBursts_q <= '0;  rdBursts_q <= '0;  wrBeats_q <= '0;  rdBeats_q <= '0;  respErr_q <= '0;
    end else begin
      wState_q <= wState_d;  rState_q <= rState_d;
      wLen_q <= wLen_d;  wCnt_q <= wCnt_d;  rLen_q <= rLen_d;  rCnt_q <= rCnt_d;
      wDoneCnt_q <= udStep(wDoneCnt_q, wDone, bOk);
      wrOut_q    <= udStep(wrOut_q, awAccept, bOk);
      rdOut_q    <= udStep(rdOut_q, arAccept, rDone);
      err_q      <= (CLEAR ? '0 : err_q) | newErr;
      errPulse_q <= |newErr;
      if (CLEAR) begin
        wrBursts_q <= '0;  rdBursts_q <= '0;  wrBeats_q <= '0;  rdBeats_q <= '0;  respErr_q <= '0;
      end else begin
        wrBursts_q <= satAdd(wrBursts_q, {1'b0, bOk});
        rdBursts_q <= satAdd(rdBursts_q, {1'b0, rDone});
        wrBeats_q  <= satAdd(wrBeats_q, {1'b0, wHs});
        rdBeats_q  <= satAdd(rdBeats_q, {1'b0, rHs});
        respErr_q  <= satAdd(respErr_q, respInc);
      end
    end
  end

  axi4_mon_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wLenFifo (
    .clk_i(ACLK), .rst_ni(ARESETN), .push_i(wFifoPush), .pop_i(wFifoPop), .data_i(AWLEN),
    .data_o(wHead), .full_o(wFull), .empty_o(wEmpty), .count_o(wCount)
  );

  axi4_mon_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rLenFifo (
    .clk_i(ACLK), .rst_ni(ARESETN), .push_i(rFifoPush), .pop_i(rFifoPop), .data_i(ARLEN),
    .data_o(rHead), .full_o(rFull), .empty_o(rEmpty), .count_o(rCount)
  );

  logic unusedBits;
  assign unusedBits = ^{AWADDR, ARADDR, wCount, rCount, 1'(ID_WIDTH)};

  assign ERR            = err_q;
  assign ERR_PULSE      = errPulse_q;
  assign WR_BURSTS      = wrBursts_q;
  assign RD_BURSTS      = rdBursts_q;
  assign WR_BEATS       = wrBeats_q;
  assign RD_BEATS       = rdBeats_q;
  assign RESP_ERR_CNT   = respErr_q;
  assign WR_OUTSTANDING = wrOut_q;
  assign RD_OUTSTANDING = rdOut_q;

endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Directed self-checking bench for axi4_protocol_monitor: each task drives one scenario
// and compares registered outputs against hand-computed values.
module tb_axi4_protocol_monitor;

  logic        ACLK = 1'b0;
  logic        ARESETN, CLEAR;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [8:0]  ERR;
  logic        ERR_PULSE;
  logic [31:0] WR_BURSTS, RD_BURSTS, WR_BEATS, RD_BEATS, RESP_ERR_CNT;
  logic [2:0]  WR_OUTSTANDING, RD_OUTSTANDING;

  int nChecks = 0;
  int nFails  = 0;

  always #5 ACLK = ~ACLK;

  axi4_protocol_monitor #(.ID_WIDTH(1), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4), .CNT_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CLEAR(CLEAR),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP),
    .ERR(ERR), .ERR_PULSE(ERR_PULSE), .WR_BURSTS(WR_BURSTS), .RD_BURSTS(RD_BURSTS),
    .WR_BEATS(WR_BEATS), .RD_BEATS(RD_BEATS), .RESP_ERR_CNT(RESP_ERR_CNT),
    .WR_OUTSTANDING(WR_OUTSTANDING), .RD_OUTSTANDING(RD_OUTSTANDING)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idleAll();
    CLEAR = 0; AWVALID = 0; WVALID = 0; WLAST = 0; BVALID = 0; ARVALID = 0; RVALID = 0; RLAST = 0;
    AWREADY = 1; WREADY = 1; BREADY = 1; ARREADY = 1; RREADY = 1;
    AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 2'b01; BRESP = 0;
    ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 2'b01; RRESP = 0;
  endtask

  task automatic doReset();
    idleAll();
    ARESETN = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    step();
  endtask

  task automatic awBeat(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    AWVALID = 1; AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b;
    step();
    AWVALID = 0;
  endtask

  task automatic arBeat(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    ARVALID = 1; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b;
    step();
    ARVALID = 0;
  endtask

  task automatic wBeat(input logic last);
    WVALID = 1; WLAST = last;
    step();
    WVALID = 0; WLAST = 0;
  endtask

  task automatic rBeat(input logic last, input logic [1:0] resp);
    RVALID = 1; RLAST = last; RRESP = resp;
    step();
    RVALID = 0; RLAST = 0; RRESP = 0;
  endtask

  task automatic bBeat(input logic [1:0] resp);
    BVALID = 1; BRESP = resp;
    step();
    BVALID = 0; BRESP = 0;
  endtask

  task automatic clearPulse();
    CLEAR = 1;
    step();
    CLEAR = 0;
  endtask

  task automatic test_reset();
    doReset();
    nChecks++; if (ERR !== 9'h000 || ERR_PULSE !== 1'b0) begin nFails++;
      $display("[TB] FAIL reset_err ERR=%h PULSE=%b want 000/0", ERR, ERR_PULSE); end
    nChecks++; if (WR_BEATS !== 0 || RD_BEATS !== 0 || WR_BURSTS !== 0 || RD_BURSTS !== 0 || RESP_ERR_CNT !== 0) begin nFails++;
      $display("[TB] FAIL reset_counters got %0d %0d %0d %0d %0d want all 0", WR_BEATS, RD_BEATS, WR_BURSTS, RD_BURSTS, RESP_ERR_CNT); end
    awBeat(32'h0, 8'd3, 3'd2, 2'b01);
    wBeat(0); wBeat(0);
    arBeat(32'h0, 8'd0, 3'd0, 2'b11);
    nChecks++; if (ERR !== 9'h080 || WR_BEATS !== 2) begin nFails++;
      $display("[TB] FAIL pre_reset ERR=%h WR_BEATS=%0d want 080/2", ERR, WR_BEATS); end
    ARESETN = 0;
    #2;
    nChecks++; if (ERR !== 9'h000 || WR_BEATS !== 0 || WR_OUTSTANDING !== 0 || RD_OUTSTANDING !== 0) begin nFails++;
      $display("[TB] FAIL mid_reset ERR=%h WR_BEATS=%0d WO=%0d RO=%0d want 0", ERR, WR_BEATS, WR_OUTSTANDING, RD_OUTSTANDING); end
    ARESETN = 1;
    step();
    awBeat(32'h40, 8'd1, 3'd2, 2'b01);
    wBeat(0); wBeat(1);
    bBeat(2'b00);
    nChecks++; if (ERR !== 9'h000 || WR_BURSTS !== 1 || WR_BEATS !== 2) begin nFails++;
      $display("[TB] FAIL post_reset_burst ERR=%h BURSTS=%0d BEATS=%0d want 000/1/2", ERR, WR_BURSTS, WR_BEATS); end
  endtask

  task automatic test_basic_write();
    doReset();
    awBeat(32'h1000, 8'd3, 3'd2, 2'b01);
    nChecks++; if (WR_OUTSTANDING !== 3'd1) begin nFails++;
      $display("[TB] FAIL basic_outstanding_up got %0d want 1", WR_OUTSTANDING); end
    wBeat(0); wBeat(0); wBeat(0); wBeat(1);
    nChecks++; if (WR_BEATS !== 4 || ERR !== 9'h000) begin nFails++;
      $display("[TB] FAIL basic_beats BEATS=%0d ERR=%h want 4/000", WR_BEATS, ERR); end
    bBeat(2'b00);
    nChecks++; if (WR_BURSTS !== 1 || WR_OUTSTANDING !== 3'd0 || ERR !== 9'h000 || RESP_ERR_CNT !== 0) begin nFails++;
      $display("[TB] FAIL basic_b BURSTS=%0d WO=%0d ERR=%h RESPERR=%0d want 1/0/000/0", WR_BURSTS, WR_OUTSTANDING, ERR, RESP_ERR_CNT); end
  endtask

  task automatic test_wlast_early();
    doReset();
    awBeat(32'h0, 8'd3, 3'd2, 2'b01);
    wBeat(0); wBeat(1);
    nChecks++; if (ERR !== 9'h001 || ERR_PULSE !== 1'b1) begin nFails++;
      $display("[TB] FAIL wlast_early ERR=%h PULSE=%b want 001/1", ERR, ERR_PULSE); end
    step();
    nChecks++; if (ERR !== 9'h001 || ERR_PULSE !== 1'b0) begin nFails++;
      $display("[TB] FAIL wlast_early_sticky ERR=%h PULSE=%b want 001/0", ERR, ERR_PULSE); end
    awBeat(32'h200, 8'd1, 3'd2, 2'b01);
    wBeat(0); wBeat(1);
    bBeat(2'b00);
    nChecks++; if (ERR !== 9'h001 || ERR_PULSE !== 1'b0 || WR_BURSTS !== 1 || WR_OUTSTANDING !== 3'd1) begin nFails++;
      $display("[TB] FAIL wlast_followup ERR=%h PULSE=%b BURSTS=%0d WO=%0d want 001/0/1/1", ERR, ERR_PULSE, WR_BURSTS, WR_OUTSTANDING); end
  endtask

  task automatic test_burst_legality();
    doReset();
    arBeat(32'hFF0, 8'd7, 3'd2, 2'b01);
    nChecks++; if (ERR !== 9'h080 || ERR_PULSE !== 1'b1) begin nFails++;
      $display("[TB] FAIL incr_4k ERR=%h PULSE=%b want 080/1", ERR, ERR_PULSE); end
    clearPulse();
    nChecks++; if (ERR !== 9'h000) begin nFails++;
      $display("[TB] FAIL clear_err got %h want 000", ERR); end
    arBeat(32'h0, 8'd4, 3'd2, 2'b10);
    nChecks++; if (ERR !== 9'h080) begin nFails++;
      $display("[TB] FAIL wrap_len4 got %h want 080", ERR); end
    clearPulse();
    arBeat(32'h08, 8'd3, 3'd2, 2'b10);
    nChecks++; if (ERR !== 9'h000 || ERR_PULSE !== 1'b0) begin nFails++;
      $display("[TB] FAIL wrap_len3 ERR=%h PULSE=%b want 000/0", ERR, ERR_PULSE); end
    awBeat(32'hFF0, 8'd3, 3'd2, 2'b01);
    nChecks++; if (ERR !== 9'h000) begin nFails++;
      $display("[TB] FAIL incr_exact_4k got %h want 000", ERR); end
    awBeat(32'h0, 8'd0, 3'd0, 2'b11);
    nChecks++; if (ERR !== 9'h080) begin nFails++;
      $display("[TB] FAIL burst_reserved got %h want 080", ERR); end
  endtask

  task automatic test_overflow();
    doReset();
    for (int i = 0; i < 4; i++) awBeat(32'h0, 8'd0, 3'd0, 2'b01);
    nChecks++; if (ERR !== 9'h000 || WR_OUTSTANDING !== 3'd4) begin nFails++;
      $display("[TB] FAIL fill_fifo ERR=%h WO=%0d want 000/4", ERR, WR_OUTSTANDING); end
    awBeat(32'h0, 8'd0, 3'd0, 2'b01);
    nChecks++; if (ERR !== 9'h040 || WR_OUTSTANDING !== 3'd4) begin nFails++;
      $display("[TB] FAIL overflow ERR=%h WO=%0d want 040/4", ERR, WR_OUTSTANDING); end
    bBeat(2'b00);
    nChecks++; if (ERR !== 9'h048 || WR_OUTSTANDING !== 3'd4 || WR_BURSTS !== 0) begin nFails++;
      $display("[TB] FAIL b_unexpected ERR=%h WO=%0d BURSTS=%0d want 048/4/0", ERR, WR_OUTSTANDING, WR_BURSTS); end
  endtask

  task automatic test_bypass_and_clear();
    doReset();
    AWVALID = 1; AWADDR = 32'h0; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
    WVALID = 1; WLAST = 1;
    step();
    AWVALID = 0; WVALID = 0; WLAST = 0;
    nChecks++; if (ERR !== 9'h000 || ERR_PULSE !== 1'b0 || WR_BEATS !== 1 || WR_OUTSTANDING !== 3'd1) begin nFails++;
      $display("[TB] FAIL bypass ERR=%h PULSE=%b BEATS=%0d WO=%0d want 000/0/1/1", ERR, ERR_PULSE, WR_BEATS, WR_OUTSTANDING); end
    bBeat(2'b00);
    nChecks++; if (ERR !== 9'h000 || WR_BURSTS !== 1 || WR_OUTSTANDING !== 3'd0) begin nFails++;
      $display("[TB] FAIL bypass_b ERR=%h BURSTS=%0d WO=%0d want 000/1/0", ERR, WR_BURSTS, WR_OUTSTANDING); end
    arBeat(32'h0, 8'd1, 3'd2, 2'b01);
    rBeat(0, 2'b00);
    nChecks++; if (RD_BEATS !== 1 || RD_OUTSTANDING !== 3'd1) begin nFails++;
      $display("[TB] FAIL pre_clear RD_BEATS=%0d RO=%0d want 1/1", RD_BEATS, RD_OUTSTANDING); end
    CLEAR = 1;
    rBeat(0, 2'b00);
    CLEAR = 0;
    nChecks++; if (ERR !== 9'h010 || ERR_PULSE !== 1'b1) begin nFails++;
      $display("[TB] FAIL clear_rlast_missing ERR=%h PULSE=%b want 010/1", ERR, ERR_PULSE); end
    nChecks++; if (WR_BEATS !== 0 || RD_BEATS !== 0 || WR_BURSTS !== 0 || RD_OUTSTANDING !== 3'd1) begin nFails++;
      $display("[TB] FAIL clear_counters WB=%0d RB=%0d WBU=%0d RO=%0d want 0/0/0/1", WR_BEATS, RD_BEATS, WR_BURSTS, RD_OUTSTANDING); end
  endtask

  task automatic test_back_to_back();
    doReset();
    wBeat(1);
    nChecks++; if (ERR !== 9'h004 || WR_BEATS !== 1) begin nFails++;
      $display("[TB] FAIL w_no_aw ERR=%h BEATS=%0d want 004/1", ERR, WR_BEATS); end
    rBeat(1, 2'b00);
    nChecks++; if (ERR !== 9'h024) begin nFails++;
      $display("[TB] FAIL r_no_ar got %h want 024", ERR); end
    arBeat(32'h100, 8'd1, 3'd3, 2'b01);
    rBeat(0, 2'b10); rBeat(1, 2'b00);
    nChecks++; if (RD_BURSTS !== 1 || RD_BEATS !== 3 || RESP_ERR_CNT !== 1 || RD_OUTSTANDING !== 3'd0) begin nFails++;
      $display("[TB] FAIL read_burst RBU=%0d RB=%0d RESP=%0d RO=%0d want 1/3/1/0", RD_BURSTS, RD_BEATS, RESP_ERR_CNT, RD_OUTSTANDING); end
    arBeat(32'h0, 8'd0, 3'd0, 2'b01);
    arBeat(32'h0, 8'd0, 3'd0, 2'b01);
    nChecks++; if (RD_OUTSTANDING !== 3'd2) begin nFails++;
      $display("[TB] FAIL b2b_outstanding got %0d want 2", RD_OUTSTANDING); end
    rBeat(1, 2'b11); rBeat(1, 2'b00);
    nChecks++; if (RD_BURSTS !== 3 || RD_OUTSTANDING !== 3'd0 || ERR !== 9'h024 || RESP_ERR_CNT !== 2) begin nFails++;
      $display("[TB] FAIL b2b_reads RBU=%0d RO=%0d ERR=%h RESP=%0d want 3/0/024/2", RD_BURSTS, RD_OUTSTANDING, ERR, RESP_ERR_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wlast_early();
    test_burst_legality();
    test_overflow();
    test_bypass_and_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
